// File: rtl/tanh_table_scheduler_if.sv
// Requester/table bundle for tanh_table_scheduler: vector requests, shared table
// operand/result, and job status/result outputs.
interface tanh_table_scheduler_if #(
  parameter int NREQ    = 2,
  parameter int HID_DIM = 24,
  parameter int DATA_W  = 16,
  parameter int OUT_W   = 8
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]                req;
  logic [NREQ*HID_DIM*DATA_W-1:0] d;
  logic [DATA_W-1:0]              tbl_d;
  logic [OUT_W-1:0]               tbl_q;
  logic                           busy;
  logic [ID_W-1:0]                grant_id;
  logic [NREQ-1:0]                done;
  logic [HID_DIM*OUT_W-1:0]       q;

  modport master (
    output req, d, tbl_q,
    input  tbl_d, busy, grant_id, done, q
  );

  modport slave (
    input  req, d, tbl_q,
    output tbl_d, busy, grant_id, done, q
  );
endinterface

// File: rtl/tanh_table_scheduler.sv
// Round-robin time-sharing of one fixed-latency tanh_table pipeline between NREQ
// vector requesters; one whole HID_DIM vector per job, one element per cycle.
module tanh_table_scheduler #(
  parameter int NREQ      = 2,
  parameter int HID_DIM   = 24,
  parameter int DATA_W    = 16,
  parameter int OUT_W     = 8,
  parameter int TABLE_LAT = 3
) (
  input logic clk,
  input logic rst,
  tanh_table_scheduler_if.slave bus
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int IDX_W = $clog2(HID_DIM);
  localparam int LAT_W = (TABLE_LAT > 1) ? $clog2(TABLE_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(HID_DIM - 1);
  localparam logic [LAT_W-1:0] LAST_DRAIN = LAT_W'(TABLE_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                   state, state_n;
  logic [ID_W-1:0]          ptr;
  logic [ID_W-1:0]          grant_id;
  logic [ID_W-1:0]          pick;
  logic [ID_W-1:0]          cand;
  logic                     any_req;
  logic                     grant;
  logic [IDX_W-1:0]         idx;
  logic [LAT_W-1:0]         drain_cnt;
  logic [DATA_W-1:0]        tbl_d;
  logic [DATA_W-1:0]        d_buf [HID_DIM];
  logic [TABLE_LAT-1:0]     pv;
  logic [IDX_W-1:0]         pidx [TABLE_LAT];
  logic [HID_DIM*OUT_W-1:0] q_buf;

  // First set request at or after the round-robin pointer.
  always_comb begin
    pick    = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % NREQ);
      if (!any_req && bus.req[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  assign grant = (state == IDLE) && any_req;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any_req) state_n = ISSUE;
      ISSUE:   if (idx == LAST_IDX) state_n = DRAIN;
      DRAIN:   if (drain_cnt == LAST_DRAIN) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Operand register leads idx by one load so element k is on tbl_d during the ISSUE
  // cycle holding idx=k; the last capture then lands exactly before DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      grant_id  <= '0;
      idx       <= '0;
      drain_cnt <= '0;
      tbl_d     <= '0;
      pv        <= '0;
      q_buf     <= '0;
      for (int unsigned i = 0; i < TABLE_LAT; i++) pidx[i] <= '0;
    end else begin
      if (grant) begin
        grant_id <= pick;
        ptr      <= ID_W'((32'(pick) + 32'd1) % NREQ);
        idx      <= '0;
        tbl_d    <= bus.d[32'(pick)*HID_DIM*DATA_W +: DATA_W];
      end
      if (state == ISSUE) begin
        drain_cnt <= '0;
        if (idx != LAST_IDX) begin
          idx   <= idx + 1'b1;
          tbl_d <= d_buf[idx + 1'b1];
        end
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;

      pv[0]   <= (state == ISSUE);
      pidx[0] <= idx;
      for (int unsigned i = 1; i < TABLE_LAT; i++) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end
      if (pv[TABLE_LAT-1]) q_buf[32'(pidx[TABLE_LAT-1])*OUT_W +: OUT_W] <= bus.tbl_q;
    end
  end

  // Vector snapshot at grant so requesters may change d afterwards.
  always_ff @(posedge clk) begin
    if (grant) begin
      for (int unsigned k = 0; k < HID_DIM; k++)
        d_buf[k] <= bus.d[(32'(pick)*HID_DIM + k)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    bus.done = '0;
    if (state == DONE) bus.done[grant_id] = 1'b1;
  end

  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = grant_id;
  assign bus.tbl_d    = tbl_d;
  assign bus.q        = q_buf;
endmodule
